// File: rtl/md_pkg.sv
// Shared encodings and decode helpers for the multiply/divide unit and the hazard controller.
// Optional macro MD_MADD_EN enables the MADD/MADDU/MSUB/MSUBU encodings.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_md_start(input logic [3:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MD_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_arith.sv
// Combinational multiply/divide datapath: (op, rs, rt, hi, lo) -> (res_hi, res_lo, div0).
// Accumulate ops are present only when MD_MADD_EN is defined.
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic [63:0] prod_s, prod_u, res;
    logic [31:0] rt_nz, a_mag, b_mag, q_mag, r_mag, q_u, r_u;

    always_comb begin
        prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_u = {32'h0, rs} * {32'h0, rt};

        // Divide by a safe non-zero value; the div0 flag tells the caller to drop the result.
        rt_nz = (rt == 32'h0) ? 32'h1 : rt;
        a_mag = rs[31] ? -rs : rs;
        b_mag = rt_nz[31] ? -rt_nz : rt_nz;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        q_u   = rs / rt_nz;
        r_u   = rs % rt_nz;

        div0 = is_div(op) && (rt == 32'h0);
        res  = {hi, lo};
        case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV:   res = {(rs[31] ? -r_mag : r_mag),
                             ((rs[31] ^ rt[31]) ? -q_mag : q_mag)};
            MD_DIVU:  res = {r_u, q_u};
`ifdef MD_MADD_EN
            MD_MADD:  res = {hi, lo} + prod_s;
            MD_MADDU: res = {hi, lo} + prod_u;
            MD_MSUB:  res = {hi, lo} - prod_s;
            MD_MSUBU: res = {hi, lo} - prod_u;
`endif
            default:  res = {hi, lo};
        endcase
        res_hi = res[63:32];
        res_lo = res[31:0];
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; owns the busy down-counter and pending result.
// Optional macro MD_MADD_EN adds the multiply-accumulate family.
//   state   | meaning
//   ST_IDLE | cnt == 0, accepts start and mthi/mtlo
//   ST_RUN  | cnt != 0, counting down; commit pending result on 1 -> 0
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        md_start,
    output logic        md_busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e         state;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
    logic [31:0]       hi_nxt, lo_nxt, res_hi, res_lo;
    logic              div0;

    md_arith u_arith (
        .op     (md_op),
        .rs     (rs_val),
        .rt     (rt_val),
        .hi     (hi),
        .lo     (lo),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    assign state    = (cnt != '0) ? ST_RUN : ST_IDLE;
    assign md_busy  = (cnt != '0);
    assign md_start = md_valid && is_md_start(md_op) && !md_busy;
    assign rdata    = (md_op == MD_MFHI) ? hi :
                      (md_op == MD_MFLO) ? lo : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= 32'h0;
            pend_lo <= 32'h0;
            hi      <= 32'h0;
            lo      <= 32'h0;
        end else begin
            cnt     <= cnt_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
        end
    end

    always_comb begin
        cnt_nxt     = cnt;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        hi_nxt      = hi;
        lo_nxt      = lo;
        unique case (state)
            ST_IDLE: begin
                if (md_start) begin
                    cnt_nxt     = is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    // A zero divisor still occupies the unit but recommits the current HI/LO.
                    pend_hi_nxt = div0 ? hi : res_hi;
                    pend_lo_nxt = div0 ? lo : res_lo;
                end else if (md_valid && (md_op == MD_MTHI)) begin
                    hi_nxt = rs_val;
                end else if (md_valid && (md_op == MD_MTLO)) begin
                    lo_nxt = rs_val;
                end
            end
            ST_RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    hi_nxt = pend_hi;
                    lo_nxt = pend_lo;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO and busy length, a monitor checks on completion.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        md_valid = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] rs_val = 32'h0;
    logic [31:0] rt_val = 32'h0;
    logic        md_start, md_busy;
    logic [31:0] hi, lo, rdata;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_valid (md_valid),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_start (md_start),
        .md_busy  (md_busy),
        .hi       (hi),
        .lo       (lo),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        int          len;
    } exp_t;

    exp_t        sb_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic [31:0] pre_hi, pre_lo;

`ifdef MD_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit ref_starts(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (MADD_ON && op >= 4'd9 && op <= 4'd12);
    endfunction

    // Reference results from plain 64-bit arithmetic on the architectural values.
    task automatic ref_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] nh, output logic [31:0] nl, output int len);
        longint sa, sb;
        logic [63:0] acc, p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {m_hi, m_lo};
        nh  = m_hi;
        nl  = m_lo;
        len = (op == 4'd3 || op == 4'd4) ? 10 : 5;
        case (op)
            4'd1: begin p = 64'(sa * sb); {nh, nl} = p; end
            4'd2: begin p = {32'h0, a} * {32'h0, b}; {nh, nl} = p; end
            4'd3: if (b != 0) begin nl = 32'(sa / sb); nh = 32'(sa % sb); end
            4'd4: if (b != 0) begin nl = a / b; nh = a % b; end
            4'd9:  {nh, nl} = acc + 64'(sa * sb);
            4'd10: {nh, nl} = acc + {32'h0, a} * {32'h0, b};
            4'd11: {nh, nl} = acc - 64'(sa * sb);
            4'd12: {nh, nl} = acc - {32'h0, a} * {32'h0, b};
            default: ;
        endcase
    endtask

    task automatic wait_idle();
        int k = 0;
        while (md_busy === 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 50) begin
            n_total++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", md_busy, k);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the issue edge with md_valid low.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit   st;
        wait_idle();
        pre_hi = m_hi;
        pre_lo = m_lo;
        md_valid = 1'b1; md_op = op; rs_val = a; rt_val = b;
        #1;
        st = ref_starts(op);
        check("md_start", {63'h0, md_start}, {63'h0, st});
        if (op == 4'd5)      check("rdata_mfhi", {32'h0, rdata}, {32'h0, m_hi});
        else if (op == 4'd6) check("rdata_mflo", {32'h0, rdata}, {32'h0, m_lo});
        else                 check("rdata_zero", {32'h0, rdata}, 64'h0);
        if (st) begin
            ref_compute(op, a, b, e.h, e.l, e.len);
            sb_q.push_back(e);
            m_hi = e.h;
            m_lo = e.l;
        end else if (op == 4'd7) m_hi = a;
        else if (op == 4'd8)     m_lo = a;
        @(posedge clk); #1;
        md_valid = 1'b0; md_op = 4'd0;
        if (!st) begin
            check("hilo_direct", {hi, lo}, {m_hi, m_lo});
            check("busy_direct", {63'h0, md_busy}, 64'h0);
        end
    endtask

    // Monitor: pops one expectation whenever busy falls.
    logic prev_busy = 1'b0;
    int   busy_len = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            if (md_busy) busy_len++;
            else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: completion with hi=%h lo=%h but nothing expected", hi, lo);
                end else begin
                    e = sb_q.pop_front();
                    check("busy_len", 64'(busy_len), 64'(e.len));
                    check("hi_commit", {32'h0, hi}, {32'h0, e.h});
                    check("lo_commit", {32'h0, lo}, {32'h0, e.l});
                end
                busy_len = 0;
            end
            prev_busy = md_busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'h0, md_busy}, 64'h0);
        check("rst_hilo", {hi, lo}, 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(4'd1, 32'hFFFFFFFF, 32'd2);
        wait_idle();
        check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
        do_op(4'd2, 32'hFFFFFFFF, 32'd2);
        wait_idle();
        check("multu_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);
        do_op(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle();
        check("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        do_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        check("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);
        do_op(4'd4, 32'd1234, 32'd0);
        wait_idle();
        check("divu_zero_hilo", {hi, lo}, 64'h00000000_80000000);

        do_op(4'd7, 32'h1234, 32'h0);
        check("mthi_hi", {32'h0, hi}, 64'h1234);
        do_op(4'd6, 32'h0, 32'h0);

        // Ops presented while the unit is running are ignored.
        do_op(4'd1, 32'd3, 32'd5);
        md_valid = 1'b1; md_op = 4'd1; rs_val = 32'd9; rt_val = 32'd9;
        repeat (2) begin
            #1 check("start_gated", {63'h0, md_start}, 64'h0);
            @(posedge clk); #1;
        end
        md_op = 4'd8; rs_val = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("mtlo_run_lo", {32'h0, lo}, {32'h0, pre_lo});
        md_op = 4'd5;
        #1 check("mfhi_run", {32'h0, rdata}, {32'h0, pre_hi});
        md_valid = 1'b0; md_op = 4'd0;
        wait_idle();
        check("run_mult_lo", {32'h0, lo}, 64'd15);

        do_op(4'd1, 32'd2, 32'd3);
        do_op(4'd4, 32'd7, 32'd2);
        wait_idle();
        check("b2b_hilo", {hi, lo}, 64'h00000001_00000003);

        // Reset while cnt == 2 discards the in-flight product.
        do_op(4'd1, 32'd3, 32'd4);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_busy", {63'h0, md_busy}, 64'h0);
        check("rst_mid_hilo", {hi, lo}, 64'h0);
        sb_q.delete();
        m_hi = 32'h0; m_lo = 32'h0;
        @(posedge clk); #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_commit", {hi, lo}, 64'h0);
        check("rst_no_busy", {63'h0, md_busy}, 64'h0);

        do_op(4'd7, 32'h0, 32'h0);
        do_op(4'd8, 32'hFFFFFFFF, 32'h0);
        do_op(4'd10, 32'd1, 32'd1);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        if (MADD_ON) check("maddu_hilo", {hi, lo}, 64'h00000001_00000000);
        else         check("maddu_off_hilo", {hi, lo}, 64'h00000000_FFFFFFFF);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            do_op(op, a, b);
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("final_hilo", {hi, lo}, {m_hi, m_lo});
        check("sb_empty", 64'(sb_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
